// File: rtl/bp_link_chain_buffered.sv
// 1-D chain of ready/valid link hops between tiles, with optional 2-entry elastic buffer per path.
// Optional per-edge egress flit counters when BP_LINK_CHAIN_STATS_EN is defined.

module bp_link_hop_path #(
    parameter int data_width_p = 64,
    parameter int buffer_p     = 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    v_i,
    input  logic [data_width_p-1:0] data_i,
    output logic                    ready_o,
    output logic                    v_o,
    output logic [data_width_p-1:0] data_o,
    input  logic                    ready_i
);

    if (buffer_p != 0) begin : g_buf
        logic [1:0][data_width_p-1:0] mem_q;
        logic [1:0] count_q, count_d;
        logic       wr_ptr_q, wr_ptr_d;
        logic       rd_ptr_q, rd_ptr_d;
        logic       enq, deq;

        // Reset masks both handshake outputs so nothing moves while held.
        assign ready_o = ~reset_i & (count_q != 2'd2);
        assign v_o     = ~reset_i & (count_q != 2'd0);
        assign data_o  = mem_q[rd_ptr_q];
        assign enq     = v_i & ready_o;
        assign deq     = v_o & ready_i;

        always_comb begin
            count_d  = count_q;
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            if (enq) wr_ptr_d = ~wr_ptr_q;
            if (deq) rd_ptr_d = ~rd_ptr_q;
            if (enq && !deq)      count_d = count_q + 2'd1;
            else if (deq && !enq) count_d = count_q - 2'd1;
        end

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                count_q  <= 2'd0;
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
            end else begin
                count_q  <= count_d;
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
            end
        end

        always_ff @(posedge clk_i) begin
            if (enq) mem_q[wr_ptr_q] <= data_i;
        end
    end else begin : g_wire
        assign v_o     = ~reset_i & v_i;
        assign data_o  = data_i;
        assign ready_o = ~reset_i & ready_i;
    end

endmodule

module bp_link_chain_buffered #(
    parameter int num_tiles_p  = 2,
    parameter int num_chan_p   = 5,
    parameter int data_width_p = 64,
    parameter int hop_buffer_p = 1,
    localparam int link_w      = data_width_p + 2
) (
    input  logic                                                clk_i,
    input  logic                                                reset_i,
    input  logic [num_tiles_p-1:0][1:0][num_chan_p-1:0][link_w-1:0] tile_link_i,
    output logic [num_tiles_p-1:0][1:0][num_chan_p-1:0][link_w-1:0] tile_link_o,
    input  logic [num_chan_p-1:0][link_w-1:0]                   edge_w_link_i,
    input  logic [num_chan_p-1:0][link_w-1:0]                   edge_e_link_i,
    output logic [num_chan_p-1:0][link_w-1:0]                   edge_w_link_o,
    output logic [num_chan_p-1:0][link_w-1:0]                   edge_e_link_o
`ifdef BP_LINK_CHAIN_STATS_EN
    ,
    output logic [1:0][num_chan_p-1:0][31:0]                    flit_cnt_o
`endif
);

    localparam int E   = 1;
    localparam int W   = 0;
    localparam int V_B = data_width_p + 1;
    localparam int R_B = data_width_p;

    // Per hop: link word arriving from / leaving toward its west and east endpoints.
    logic [num_tiles_p:0][num_chan_p-1:0][link_w-1:0] hop_w_in, hop_e_in, hop_w_out, hop_e_out;

    for (genvar k = 0; k <= num_tiles_p; k++) begin : g_hop
        if (k == 0) begin : g_wedge
            assign hop_w_in[k]   = edge_w_link_i;
            assign edge_w_link_o = hop_w_out[k];
        end else begin : g_wtile
            assign hop_w_in[k]         = tile_link_i[k-1][E];
            assign tile_link_o[k-1][E] = hop_w_out[k];
        end

        if (k == num_tiles_p) begin : g_eedge
            assign hop_e_in[k]   = edge_e_link_i;
            assign edge_e_link_o = hop_e_out[k];
        end else begin : g_etile
            assign hop_e_in[k]       = tile_link_i[k][W];
            assign tile_link_o[k][W] = hop_e_out[k];
        end

        for (genvar c = 0; c < num_chan_p; c++) begin : g_ch
            logic                    e_v, e_rdy, w_v, w_rdy;
            logic [data_width_p-1:0] e_data, w_data;

            bp_link_hop_path #(
                .data_width_p(data_width_p),
                .buffer_p    (hop_buffer_p)
            ) u_east (
                .clk_i  (clk_i),
                .reset_i(reset_i),
                .v_i    (hop_w_in[k][c][V_B]),
                .data_i (hop_w_in[k][c][data_width_p-1:0]),
                .ready_o(e_rdy),
                .v_o    (e_v),
                .data_o (e_data),
                .ready_i(hop_e_in[k][c][R_B])
            );

            bp_link_hop_path #(
                .data_width_p(data_width_p),
                .buffer_p    (hop_buffer_p)
            ) u_west (
                .clk_i  (clk_i),
                .reset_i(reset_i),
                .v_i    (hop_e_in[k][c][V_B]),
                .data_i (hop_e_in[k][c][data_width_p-1:0]),
                .ready_o(w_rdy),
                .v_o    (w_v),
                .data_o (w_data),
                .ready_i(hop_w_in[k][c][R_B])
            );

            assign hop_e_out[k][c] = {e_v, w_rdy, e_data};
            assign hop_w_out[k][c] = {w_v, e_rdy, w_data};
        end
    end

`ifdef BP_LINK_CHAIN_STATS_EN
    logic [1:0][num_chan_p-1:0][31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int c = 0; c < num_chan_p; c++) begin
            if (edge_e_link_o[c][V_B] && edge_e_link_i[c][R_B] && (cnt_q[E][c] != '1))
                cnt_d[E][c] = cnt_q[E][c] + 32'd1;
            if (edge_w_link_o[c][V_B] && edge_w_link_i[c][R_B] && (cnt_q[W][c] != '1))
                cnt_d[W][c] = cnt_q[W][c] + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign flit_cnt_o = cnt_q;
`endif

endmodule
